// File: rtl/ifu_fetch_queue_pkg.sv
// Shared widths, reset-PC default and queue entry type for the instruction fetch queue.
package ifu_fetch_queue_pkg;

  localparam int unsigned RegWidth   = 64;
  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned INSTWide   = 32;

  localparam logic [RegWidth-1:0] DefaultResetPc = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [INSTWide-1:0] inst;
    logic [RegWidth-1:0] pc;
  } ifq_entry_t;

  // Pick the 32-bit instruction word out of a fetched doubleword using PC[2].
  function automatic logic [INSTWide-1:0] sel_word(input logic [63:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Parametrised synchronous FIFO with flush; a flush and a push in the same cycle leave one entry.
module ifq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d, waddr;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    do_pop = pop_i && (cnt_q != '0) && !flush_i;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
    waddr   = wr_d;
    do_push = push_i && ((cnt_d != CntW'(Depth)) || do_pop);
    if (do_push) begin
      wr_d  = bump(wr_d);
      cnt_d = cnt_d + CntW'(1);
    end
    if (do_pop) begin
      rd_d  = bump(rd_d);
      cnt_d = cnt_d - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[waddr] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues cache fetches, tracks in-flight PCs, drops stale responses.
// Optional macro IFQ_BYPASS_EN presents a response at the head in its arrival cycle.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int unsigned         QDEPTH    = 4,
  parameter int unsigned         MAX_OUTST = 2,
  parameter logic [RegWidth-1:0] RESET_PC  = DefaultResetPc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  isIntrPC,
  input  logic [RegWidth-1:0]   IntrPC,
  input  logic                  is_jump,
  input  logic [RegWidth-1:0]   JumpPc,
  output logic                  cache_req,
  output logic [MemAddrBus-1:0] addr_inst,
  input  logic                  cache_ready,
  input  logic                  cache_valid,
  input  logic [63:0]           inst_i,
  output logic                  if_valid,
  output logic [INSTWide-1:0]   inst_o,
  output logic [RegWidth-1:0]   pc_o,
  input  logic                  id_allow_in
);

  localparam int unsigned CntW  = $clog2(QDEPTH) + 1;
  localparam int unsigned PcCnt = $clog2(MAX_OUTST) + 1;
  localparam int unsigned OutW  = $clog2(MAX_OUTST + 1);

  logic [RegWidth-1:0] pc_q, pc_d, skid_pc_q, skid_pc_d, req_pc, redir_pc, resp_pc;
  logic                skid_vld_q, skid_vld_d, redir, hs, resp_ok, flush;
  logic [OutW-1:0]     outst_q, outst_d, disc_q, disc_d;
  logic [31:0]         in_flight;
  logic [CntW-1:0]     q_cnt;
  logic [PcCnt-1:0]    pcf_cnt;
  logic                q_empty, q_push, q_pop, bypass;
  logic [INSTWide-1:0] resp_inst;
  ifq_entry_t          q_wdata, q_head;

  assign redir    = isIntrPC | is_jump;
  assign redir_pc = isIntrPC ? IntrPC : JumpPc;
  assign flush    = rst | redir;

  // A live redirect beats a held one, which beats the sequential PC.
  assign req_pc    = redir ? redir_pc : (skid_vld_q ? skid_pc_q : pc_q);
  assign addr_inst = req_pc[MemAddrBus-1:0];

  // Discarded responses still occupy the cache, so they count as outstanding.
  assign in_flight = 32'(outst_q) + 32'(disc_q);
  assign cache_req = !rst && (in_flight < MAX_OUTST) && ((32'(q_cnt) + in_flight) < QDEPTH);
  assign hs        = cache_req & cache_ready;

  assign resp_ok   = cache_valid && (disc_q == '0) && (pcf_cnt != '0) && !redir && !rst;
  assign resp_inst = sel_word(inst_i, resp_pc[2]);
  assign q_wdata   = '{inst: resp_inst, pc: resp_pc};
  assign q_empty   = (q_cnt == '0);
  assign q_pop     = id_allow_in && !q_empty;

`ifdef IFQ_BYPASS_EN
  assign bypass = resp_ok && q_empty;
  assign q_push = resp_ok && !(bypass && id_allow_in);
`else
  assign bypass = 1'b0;
  assign q_push = resp_ok;
`endif

  always_comb begin
    if_valid = !q_empty || bypass;
    inst_o   = '0;
    pc_o     = '0;
    if (bypass) begin
      inst_o = resp_inst;
      pc_o   = resp_pc;
    end else if (!q_empty) begin
      inst_o = q_head.inst;
      pc_o   = q_head.pc;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    skid_vld_d = skid_vld_q;
    skid_pc_d  = skid_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (hs) begin
      pc_d       = req_pc + RegWidth'(4);
      skid_vld_d = 1'b0;
    end else if (redir) begin
      skid_vld_d = 1'b1;
      skid_pc_d  = redir_pc;
    end
    if (redir) begin
      // Everything still in flight is stale; a response arriving now is dropped directly.
      disc_d  = OutW'(in_flight - 32'(cache_valid));
      outst_d = OutW'(hs);
    end else begin
      if (cache_valid) begin
        if (disc_q != '0) begin
          disc_d = disc_q - OutW'(1);
        end else if (outst_q != '0) begin
          outst_d = outst_q - OutW'(1);
        end
      end
      if (hs) outst_d = outst_d + OutW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      skid_vld_q <= 1'b0;
      skid_pc_q  <= '0;
      outst_q    <= '0;
      disc_q     <= OutW'(in_flight - 32'(cache_valid));
    end else begin
      pc_q       <= pc_d;
      skid_vld_q <= skid_vld_d;
      skid_pc_q  <= skid_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  ifq_fifo #(
    .Width ($bits(ifq_entry_t)),
    .Depth (QDEPTH)
  ) u_inst_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .count_o (q_cnt)
  );

  ifq_fifo #(
    .Width (RegWidth),
    .Depth (MAX_OUTST)
  ) u_pc_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (hs),
    .wdata_i (req_pc),
    .pop_i   (resp_ok),
    .rdata_o (resp_pc),
    .count_o (pcf_cnt)
  );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomised bench for ifu_fetch_queue: in-order cache model, queue-based reference, scoreboard.
module tb_ifu_fetch_queue;

  localparam int unsigned QD  = 4;
  localparam int unsigned MO  = 2;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
`ifdef IFQ_BYPASS_EN
  localparam int  Slack  = 0;
  localparam bit  Bypass = 1'b1;
`else
  localparam int  Slack  = 1;
  localparam bit  Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, isIntrPC, is_jump, cache_ready, cache_valid, id_allow_in;
  logic [63:0] IntrPC, JumpPc, inst_i, pc_o;
  logic        cache_req, if_valid;
  logic [31:0] addr_inst, inst_o;

  ifu_fetch_queue #(
    .QDEPTH    (QD),
    .MAX_OUTST (MO),
    .RESET_PC  (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .isIntrPC    (isIntrPC),
    .IntrPC      (IntrPC),
    .is_jump     (is_jump),
    .JumpPc      (JumpPc),
    .cache_req   (cache_req),
    .addr_inst   (addr_inst),
    .cache_ready (cache_ready),
    .cache_valid (cache_valid),
    .inst_i      (inst_i),
    .if_valid    (if_valid),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .id_allow_in (id_allow_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: requests the cache still owes (with whether they are still wanted),
  // instructions the IDU should see in order, and the architectural next fetch address.
  logic [63:0] fl_pc[$];
  bit          fl_live[$];
  logic [95:0] exq[$];
  logic [63:0] m_pc, m_skid;
  bit          m_skid_v, prev_rst;
  int          p_ready, p_allow, p_resp, p_jump, p_intr, p_rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic knobs(input int rdy, input int alw, input int rsp, input int jmp, input int itr,
                       input int rs);
    p_ready = rdy; p_allow = alw; p_resp = rsp; p_jump = jmp; p_intr = itr; p_rst = rs;
  endtask

  task automatic step();
    logic [63:0] tgt, exp_addr, rpc;
    bit          redir, exp_req, lv;
    int          tot;
    @(posedge clk);
    #1;
    rst         = chance(p_rst);
    is_jump     = chance(p_jump);
    isIntrPC    = chance(p_intr);
    JumpPc      = {32'h0, 16'h8000, 14'($urandom), 2'b00};
    IntrPC      = {32'h0, 16'h8000, 14'($urandom), 2'b00};
    cache_ready = chance(p_ready);
    id_allow_in = chance(p_allow);
    cache_valid = (fl_pc.size() > 0) && chance(p_resp);
    inst_i      = {$urandom, $urandom};
    #1;
    redir = is_jump || isIntrPC;
    tgt   = isIntrPC ? IntrPC : JumpPc;
    tot   = fl_pc.size();
    if (rst) begin
      check("cache_req_in_reset", {63'b0, cache_req}, 64'd0);
      if (cache_valid) begin
        void'(fl_pc.pop_front());
        void'(fl_live.pop_front());
      end
      foreach (fl_live[i]) fl_live[i] = 1'b0;
      exq.delete();
      m_pc     = RPC;
      m_skid_v = 1'b0;
    end else begin
      if (prev_rst) begin
        check("reset_if_valid", {63'b0, if_valid}, 64'd0);
        check("reset_inst_o", {32'b0, inst_o}, 64'd0);
        check("reset_pc_o", pc_o, 64'd0);
      end
      exp_req = (tot < int'(MO)) && ((exq.size() + tot) < int'(QD));
      check("cache_req", {63'b0, cache_req}, {63'b0, exp_req});
      exp_addr = redir ? tgt : (m_skid_v ? m_skid : m_pc);
      if (cache_req) check("addr_inst", {32'b0, addr_inst}, {32'b0, exp_addr[31:0]});
      if (cache_valid) begin
        rpc = fl_pc.pop_front();
        lv  = fl_live.pop_front();
        if (lv && !redir) exq.push_back({rpc[2] ? inst_i[63:32] : inst_i[31:0], rpc});
      end
      if (redir) begin
        foreach (fl_live[i]) fl_live[i] = 1'b0;
        exq.delete();
      end
      if (cache_req && cache_ready) begin
        fl_pc.push_back(exp_addr);
        fl_live.push_back(1'b1);
        m_pc     = exp_addr + 64'd4;
        m_skid_v = 1'b0;
      end else if (redir) begin
        m_skid_v = 1'b1;
        m_skid   = tgt;
      end
    end
    prev_rst = rst;
  endtask

  // Scoreboard monitor: the head must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && !is_jump && !isIntrPC) begin
      if (if_valid) begin
        if (exq.size() == 0) begin
          check("spurious_if_valid", {63'b0, if_valid}, 64'd0);
        end else begin
          check("inst_o", {32'b0, inst_o}, {32'b0, exq[0][95:64]});
          check("pc_o", pc_o, exq[0][63:0]);
          if (id_allow_in) void'(exq.pop_front());
        end
      end else if (exq.size() > Slack) begin
        check("if_valid_missing", {63'b0, if_valid}, 64'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; is_jump = 1'b0; isIntrPC = 1'b0; JumpPc = '0; IntrPC = '0;
    cache_ready = 1'b0; cache_valid = 1'b0; inst_i = '0; id_allow_in = 1'b0;
    m_pc = RPC; m_skid = '0; m_skid_v = 1'b0; prev_rst = 1'b1;

    knobs(0, 0, 0, 0, 0, 100);
    repeat (3) step();

    // Streaming fetch with one-cycle responses.
    knobs(100, 100, 100, 0, 0, 0);
    repeat (20) step();

    // IDU stall fills the queue; the request must stop.
    knobs(100, 0, 100, 0, 0, 0);
    repeat (10) step();
    check("stall_cache_req", {63'b0, cache_req}, 64'd0);
    knobs(100, 100, 100, 0, 0, 0);
    repeat (10) step();

    // Jump with two requests outstanding.
    knobs(100, 100, 0, 0, 0, 0);
    repeat (3) step();
    knobs(0, 100, 0, 100, 0, 0);
    step();
    knobs(100, 100, 100, 0, 0, 0);
    repeat (10) step();

    // Simultaneous interrupt and jump.
    knobs(100, 100, 100, 100, 100, 0);
    step();
    knobs(100, 100, 100, 0, 0, 0);
    repeat (6) step();

    // Redirect held while the cache is not ready.
    knobs(0, 100, 100, 100, 0, 0);
    step();
    knobs(0, 100, 100, 0, 0, 0);
    repeat (2) step();
    knobs(100, 100, 100, 0, 0, 0);
    repeat (6) step();

    // Head latency of a response into an empty queue.
    knobs(0, 100, 100, 0, 0, 0);
    repeat (6) step();
    knobs(100, 0, 0, 0, 0, 0);
    step();
    knobs(0, 0, 100, 0, 0, 0);
    step();
    check("resp_latency_n", {63'b0, if_valid}, {63'b0, Bypass});
    knobs(0, 0, 0, 0, 0, 0);
    step();
    check("resp_latency_n1", {63'b0, if_valid}, 64'd1);

    // Random traffic including redirects and mid-run resets.
    knobs(70, 60, 60, 4, 2, 1);
    repeat (3000) step();
    knobs(100, 100, 100, 0, 0, 0);
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
